// File: rtl/cone_eval_arbiter.sv
// cone_eval_arbiter
// Round-robin front end that shares one registered 5-input timing-cone
// evaluator among NUM_REQ requesters. Two fixed pipeline stages:
//   stage 1 : {r_s1_valid, r_s1_id, r_s1_op}   operands captured at grant
//   stage 2 : {r_rsp_valid, r_rsp_id, r_rsp_y} registered cone result
//
// Handshake rules (requester side and response side alike):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A source holds valid and its payload unchanged until that transfer;
//   ready never depends on the payload. The response side holds rsp_id and
//   rsp_y stable while rsp_valid is high and rsp_ready is low.
module cone_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [5*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_y,
  output logic                 busy
);

  // Stage 1 registers
  logic            r_s1_valid;
  logic [ID_W-1:0] r_s1_id;
  logic [4:0]      r_s1_op;

  // Stage 2 (output) registers
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic            r_rsp_y;

  // Round-robin pointer: index of the highest-priority requester
  logic [ID_W-1:0] r_ptr;

  // Pipeline flow control
  logic w_s2_free;
  logic w_s1_adv;
  logic w_s1_free;

  // Arbitration results
  logic            w_found_hi;
  logic            w_found_lo;
  logic [ID_W-1:0] w_win_hi;
  logic [ID_W-1:0] w_win_lo;
  logic            w_found;
  logic [ID_W-1:0] w_win;
  logic            w_accept;
  logic [4:0]      w_win_op;
  logic [ID_W-1:0] w_ptr_next;
  logic            w_cone_y;

  assign w_s2_free = !r_rsp_valid || rsp_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s1_adv;

  // Round-robin search: lowest valid index at or above r_ptr, else lowest
  // valid index overall (the wrap-around part of the scan). The descending
  // loop lets the last hit, i.e. the lowest index, win.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found_lo = 1'b1;
        w_win_lo   = ID_W'(i);
        if (ID_W'(i) >= r_ptr) begin
          w_found_hi = 1'b1;
          w_win_hi   = ID_W'(i);
        end
      end
    end
  end

  assign w_found    = w_found_lo;
  assign w_win      = w_found_hi ? w_win_hi : w_win_lo;
  // Explicit wrap so non-power-of-two NUM_REQ never produces unused codes
  assign w_ptr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // One-hot grant to the winner when stage 1 can take a new operand set
  always_comb begin
    req_ready = '0;
    if (enable && w_s1_free && !rst && w_found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ID_W'(i) == w_win) req_ready[i] = 1'b1;
      end
    end
  end

  assign w_accept = |(req_valid & req_ready);

  // Operand mux selecting the winner's 5-bit slice
  always_comb begin
    w_win_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) w_win_op = req_data[5*i +: 5];
    end
  end

  // Cone function; the third term is always 0 but is kept so the logic
  // matches the evaluation cone gate for gate.
  assign w_cone_y = ~((r_s1_op[1] & r_s1_op[2] & r_s1_op[3]) |
                      (r_s1_op[4] & ~r_s1_op[0]) |
                      ((r_s1_op[0] & r_s1_op[3]) & ~r_s1_op[3]));

  // Stage 1: load on accept, empty when its content moves to stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_op    <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_id    <= w_win;
      r_s1_op    <= w_win_op;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: refill whenever the consumer has taken (or never had) a result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= 1'b0;
    end else if (w_s2_free) begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_id <= r_s1_id;
        r_rsp_y  <= w_cone_y;
      end
    end
  end

  // Pointer moves past the granted requester only on an accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign busy      = r_s1_valid | r_rsp_valid;

endmodule

// File: tb/tb_cone_eval_arbiter.sv
// tb_cone_eval_arbiter
// Per-requester operand queues feed the arbiter; a reference arbitration and
// pipeline-occupancy model predicts req_ready, busy and rsp_valid each cycle,
// and a scoreboard queue holds the expected {id, y} of every accepted set.
module tb_cone_eval_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DEPTH   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [NUM_REQ-1:0]   req_valid;
  logic [5*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_y;
  logic                 busy;

  cone_eval_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Counters
  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {rsp_id, rsp_y}
  logic [ID_W:0] exp_q[$];

  // Requester operand queues
  logic [4:0] src_mem [NUM_REQ][DEPTH];
  int         src_wr  [NUM_REQ];
  int         src_rd  [NUM_REQ];

  // Reference model state
  int                   m_ptr;
  bit                   m_s1;
  bit                   m_s2;
  logic [NUM_REQ-1:0]   acc_vec;
  logic [NUM_REQ-1:0]   prev_pend;
  logic [5*NUM_REQ-1:0] prev_data;
  bit                   prev_stall;
  logic [ID_W-1:0]      prev_id;
  logic                 prev_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cone reference: output is 0 when n4 is set without n0, or n3..n1 all set
  function automatic logic ref_y(input logic [4:0] op);
    if (op[4] && !op[0]) return 1'b0;
    if (op[3:1] == 3'b111) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int r, input logic [4:0] op);
    src_mem[r][src_wr[r] % DEPTH] = op;
    src_wr[r]++;
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NUM_REQ; i++) if (src_rd[i] != src_wr[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor + model step, called at the falling edge
  task automatic mon();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [ID_W:0]      exp_rsp;
    bit                 found;
    int                 win;
    int                 idx;
    bit                 s2_free;
    bit                 s1_free;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      m_ptr = 0; m_s1 = 0; m_s2 = 0;
      exp_q.delete();
      acc_vec = '0; prev_pend = '0; prev_stall = 0;
      return;
    end
    chk("busy", busy, m_s1 | m_s2);
    chk("rsp_valid", rsp_valid, m_s2);
    chk("ready_onehot", ($countones(req_ready) <= 1), 1);
    if (prev_stall) begin
      chk("stall_hold_id", rsp_id, prev_id);
      chk("stall_hold_y", rsp_y, prev_y);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (prev_pend[i]) begin
        chk("req_hold_valid", req_valid[i], 1);
        chk("req_hold_data", req_data[5*i +: 5], prev_data[5*i +: 5]);
      end
    end
    found = 0; win = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin found = 1; win = idx; end
    end
    s2_free = !m_s2 || rsp_ready;
    s1_free = !m_s1 || s2_free;
    exp_rdy = '0;
    if (enable && s1_free && found) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {rsp_id, rsp_y}, 32'hffff_ffff);
      end else begin
        exp_rsp = exp_q.pop_front();
        chk("rsp_id_y", {rsp_id, rsp_y}, exp_rsp);
      end
    end
    acc_vec = req_valid & exp_rdy;
    if (acc_vec != 0) begin
      exp_q.push_back({ID_W'(win), ref_y(req_data[5*win +: 5])});
      m_ptr = (win + 1) % NUM_REQ;
    end
    if (s2_free) m_s2 = m_s1;
    m_s1 = (acc_vec != 0) || (m_s1 && !s2_free);
    prev_stall = rsp_valid && !rsp_ready;
    prev_id    = rsp_id;
    prev_y     = rsp_y;
    prev_pend  = req_valid & ~acc_vec;
    prev_data  = req_data;
  endtask

  // Requester drivers: retire accepted operands, present queue heads
  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_vec[i]) src_rd[i]++;
      if (src_rd[i] != src_wr[i]) begin
        req_valid[i]       = 1'b1;
        req_data[5*i +: 5] = src_mem[i][src_rd[i] % DEPTH];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[5*i +: 5] = 5'($urandom_range(0, 31));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || (req_valid != 0) || src_pending()) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", {busy, |req_valid}, 0);
  endtask

  initial begin
    int first_c, last_c, n_rsp, n_acc, exp_id, got_id, r;
    rst = 1'b1; enable = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_data = '0;
    acc_vec = '0; prev_pend = '0; prev_stall = 0; m_ptr = 0; m_s1 = 0; m_s2 = 0;
    for (int i = 0; i < NUM_REQ; i++) begin src_wr[i] = 0; src_rd[i] = 0; end

    // Reset, with a request pending that must not be granted during rst
    tick();
    push(1, 5'b00011);
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_req_ready_direct", req_ready, 0);
    rst = 1'b0;
    wait_idle(20);

    // T1: single request from requester 2
    push(2, 5'b01110);
    tick();
    chk("t1_grant", req_ready, 4'b0100);
    tick();
    chk("t1_s1_no_rsp", rsp_valid, 0);
    chk("t1_s1_busy", busy, 1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 2);
    chk("t1_rsp_y", rsp_y, 0);
    tick();
    chk("t1_after_valid", rsp_valid, 0);
    chk("t1_after_busy", busy, 0);

    // T2: truth coverage on requester 0, back-to-back
    push(0, 5'b00000); push(0, 5'b10000); push(0, 5'b11001);
    push(0, 5'b11111); push(0, 5'b00110);
    first_c = -1; last_c = -1; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_rsp++;
      end
    end
    chk("t2_rsp_count", n_rsp, 5);
    chk("t2_rsp_span", last_c - first_c + 1, 5);
    wait_idle(20);

    // T3: all requesters valid, round-robin order from ptr=1
    for (int k = 0; k < 3; k++) for (int i = 0; i < NUM_REQ; i++) push(i, 5'($urandom_range(0, 31)));
    exp_id = 1; n_acc = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && n_acc < 12; c++) begin
      tick();
      if (acc_vec != 0) begin
        got_id = 0;
        for (int i = 0; i < NUM_REQ; i++) if (acc_vec[i]) got_id = i;
        chk("t3_rr_order", got_id, exp_id);
        exp_id = (exp_id + 1) % NUM_REQ;
        if (first_c < 0) first_c = c;
        last_c = c;
        n_acc++;
      end
    end
    chk("t3_accept_count", n_acc, 12);
    chk("t3_accept_span", last_c - first_c + 1, 12);
    wait_idle(30);

    // T4: backpressure on a stream from requester 1
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(1, 5'($urandom_range(0, 31)));
    for (int c = 0; c < 6; c++) tick();
    chk("t4_ready_blocked", req_ready, 0);
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_id", rsp_id, 1);
    rsp_ready = 1'b1;
    wait_idle(30);
    chk("t4_scoreboard_empty", exp_q.size(), 0);

    // T5: enable low drains in-flight work, then resumes at ptr=2
    rsp_ready = 1'b0;
    push(1, 5'b10001); push(1, 5'b01010);
    for (int c = 0; c < 4; c++) tick();
    enable = 1'b0;
    push(0, 5'b00100); push(3, 5'b11000);
    for (int c = 0; c < 3; c++) tick();
    chk("t5_busy_held", busy, 1);
    chk("t5_no_grant", req_ready, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("t5_busy_drained", busy, 0);
    chk("t5_rsp_valid_drained", rsp_valid, 0);
    chk("t5_still_no_grant", req_ready, 0);
    chk("t5_pending", req_valid, 4'b1001);
    enable = 1'b1;
    #1;
    chk("t5_resume_grant", req_ready, 4'b1000);
    wait_idle(20);

    // T6: reset with two sets in flight
    rsp_ready = 1'b0;
    push(2, 5'b00001); push(2, 5'b10000);
    for (int c = 0; c < 4; c++) tick();
    chk("t6_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_rd[i] = src_wr[i];
    chk("t6_rsp_valid_cleared", rsp_valid, 0);
    chk("t6_busy_cleared", busy, 0);
    rsp_ready = 1'b1;
    push(1, 5'b01111); push(0, 5'b00111);
    tick();
    chk("t6_ptr_zero_grant", req_ready, 4'b0001);
    wait_idle(20);

    // Random traffic with random backpressure and enable
    for (int c = 0; c < 250; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, NUM_REQ - 1);
        if (src_wr[r] - src_rd[r] < DEPTH - 2) push(r, 5'($urandom_range(0, 31)));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      tick();
    end
    enable = 1'b1; rsp_ready = 1'b1;
    wait_idle(300);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
